// File: rtl/spi_hub_pkg.sv
// Shared definitions for the scan-select hub host controller.
package spi_hub_pkg;

  // Width of the hub's slave-select shift register (32-way decode).
  localparam int HUB_ADDR_W = 5;

  // Transaction sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    DONE
  } state_t;

  // Bit-counter width that holds the larger phase length without wrapping.
  function automatic int bit_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/spi_hub_master_sclk_tick_gen.sv
// SCLK half-period timer: CLK_DIV cycles per half, low half first.
// The first enabled cycle is a setup cycle, so the first half starts one
// cycle after enable rises. With i_hold_low the half ends without flipping
// to high (used for the idle gap between address and data).
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_hold_low,
  output logic o_load_tick,
  output logic o_rise_tick,
  output logic o_fall_tick,
  output logic o_sample_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_cnt;
  logic             r_phase;   // 0 = low half, 1 = high half
  logic             r_armed;   // setup cycle done
  logic             w_half_end;

  assign w_half_end    = i_en && r_armed && (r_cnt == DIV_W'(CLK_DIV - 1));
  // First cycle of a low half: the safe moment to change SIN/REGSEL.
  assign o_load_tick   = i_en && r_armed && !r_phase && (r_cnt == '0);
  assign o_rise_tick   = w_half_end && !r_phase;
  assign o_fall_tick   = w_half_end && r_phase;
  // Last cycle of the high half doubles as the return-bit sample point.
  assign o_sample_tick = w_half_end && r_phase;

  // Half-period counter; cleared whenever the divider is not in use.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_armed <= 1'b0;
    end else if (!r_armed) begin
      r_armed <= 1'b1;
    end else if (w_half_end) begin
      r_cnt <= '0;
      if (!i_hold_low) begin
        r_phase <= ~r_phase;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_hub_master.sv
// Host controller for the serial scan-select hub: shifts a slave address
// in with REGSEL=1, then exchanges one data word with the selected slave.
module spi_hub_master
  import spi_hub_pkg::*;
#(
  parameter int ADDR_W  = HUB_ADDR_W,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_hub_regsel,
  output logic              o_hub_sclk,
  output logic              o_hub_sin,
  input  logic              i_hub_sout
);

  localparam int CNT_W = bit_cnt_w(ADDR_W, DATA_W);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr_sr, w_addr_sr_next;
  logic [DATA_W-1:0]   r_tx_sr, w_tx_sr_next;
  logic [DATA_W-1:0]   r_rx_sr, w_rx_sr_next;
  logic [DATA_W-1:0]   r_rx_data, w_rx_data_next;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                r_regsel, w_regsel_next;
  logic                r_sclk, w_sclk_next;
  logic                r_sin, w_sin_next;

  logic                w_tick_en;
  logic                w_load_tick, w_rise_tick, w_fall_tick, w_sample_tick;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rx_shift;

  assign w_tick_en  = (r_state == ADDR) || (r_state == GAP) || (r_state == DATA);
  // A new request is taken when idle, or in the DONE cycle for back-to-back.
  assign w_accept   = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_rx_shift = (r_rx_sr << 1) | DATA_W'(i_hub_sout);

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (w_tick_en),
    .i_hold_low    (r_state == GAP),
    .o_load_tick   (w_load_tick),
    .o_rise_tick   (w_rise_tick),
    .o_fall_tick   (w_fall_tick),
    .o_sample_tick (w_sample_tick)
  );

  // Next-state and next-output decode; SIN/REGSEL move only on load ticks.
  always_comb begin
    w_state_next   = r_state;
    w_addr_sr_next = r_addr_sr;
    w_tx_sr_next   = r_tx_sr;
    w_rx_sr_next   = r_rx_sr;
    w_rx_data_next = r_rx_data;
    w_bit_cnt_next = r_bit_cnt;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_regsel_next  = r_regsel;
    w_sclk_next    = r_sclk;
    w_sin_next     = r_sin;

    case (r_state)
      IDLE: begin
        w_sclk_next   = 1'b0;
        w_regsel_next = 1'b0;
      end

      ADDR: begin
        if (w_load_tick) begin
          w_regsel_next = 1'b1;
          w_sin_next    = r_addr_sr[ADDR_W-1];
        end
        if (w_rise_tick) begin
          w_sclk_next = 1'b1;
        end
        // This falling edge, with REGSEL still high, latches the hub decode.
        if (w_fall_tick) begin
          w_sclk_next    = 1'b0;
          w_addr_sr_next = r_addr_sr << 1;
          if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
            w_bit_cnt_next = '0;
            w_state_next   = GAP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end

      GAP: begin
        if (w_load_tick) begin
          w_regsel_next = 1'b0;
          w_sin_next    = 1'b0;
        end
        // End of the silent half: no SCLK edge, straight into data.
        if (w_rise_tick) begin
          w_state_next = DATA;
        end
      end

      DATA: begin
        if (w_load_tick) begin
          w_sin_next = r_tx_sr[DATA_W-1];
        end
        if (w_rise_tick) begin
          w_sclk_next = 1'b1;
        end
        if (w_sample_tick) begin
          w_rx_sr_next = w_rx_shift;
        end
        if (w_fall_tick) begin
          w_sclk_next  = 1'b0;
          w_tx_sr_next = r_tx_sr << 1;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_bit_cnt_next = '0;
            w_rx_data_next = w_rx_shift;
            w_done_next    = 1'b1;
            w_state_next   = DONE;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end

      DONE: begin
        w_sin_next   = 1'b0;
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_accept) begin
      w_addr_sr_next = i_addr;
      w_tx_sr_next   = i_tx_data;
      w_rx_sr_next   = '0;
      w_bit_cnt_next = '0;
      w_busy_next    = 1'b1;
      w_state_next   = ADDR;
    end
  end

  // State and output registers; reset aborts any transfer without DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_addr_sr <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_regsel  <= 1'b0;
      r_sclk    <= 1'b0;
      r_sin     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_addr_sr <= w_addr_sr_next;
      r_tx_sr   <= w_tx_sr_next;
      r_rx_sr   <= w_rx_sr_next;
      r_rx_data <= w_rx_data_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_regsel  <= w_regsel_next;
      r_sclk    <= w_sclk_next;
      r_sin     <= w_sin_next;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_rx_data    = r_rx_data;
  assign o_hub_regsel = r_regsel;
  assign o_hub_sclk   = r_sclk;
  assign o_hub_sin    = r_sin;

endmodule

// File: tb/tb_spi_hub_master.sv
// Bench for spi_hub_master with a hub + 32-slave model and a DONE scoreboard.
module tb_spi_hub_master;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int DIV = 2;
  localparam int LAT = 2 * DIV * (AW + DW) + DIV + 1;  // accept edge -> DONE edge

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_tx_data;
  logic          o_busy, o_done, o_hub_regsel, o_hub_sclk, o_hub_sin;
  logic [DW-1:0] o_rx_data;
  logic          sout = 1'b0;

  always #5 clk = ~clk;

  spi_hub_master #(
    .DATA_W  (DW),
    .CLK_DIV (DIV)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_addr       (i_addr),
    .i_tx_data    (i_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rx_data    (o_rx_data),
    .o_hub_regsel (o_hub_regsel),
    .o_hub_sclk   (o_hub_sclk),
    .o_hub_sin    (o_hub_sin),
    .i_hub_sout   (sout)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            done_count = 0;
  logic [DW-1:0] pat [32];

  // Hub + slave model state
  logic [AW-1:0] hub_shift = '0;
  logic [AW-1:0] hub_sel = '0;
  int            addr_pulses = 0;
  int            data_pulses = 0;
  int            slave_pulses [32];
  logic [DW-1:0] mout = '0;
  int            data_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_hub();
    addr_pulses = 0;
    data_pulses = 0;
    mout = '0;
    foreach (slave_pulses[i]) slave_pulses[i] = 0;
  endtask

  // Hub: select register shifts on SCLK rise while REGSEL=1; decode latches
  // on SCLK fall with REGSEL=1; with REGSEL=0 SCLK/SIN go to the selected slave.
  always @(posedge o_hub_sclk) begin
    if (o_hub_regsel) begin
      hub_shift = {hub_shift[AW-2:0], o_hub_sin};
      addr_pulses++;
    end else begin
      data_pulses++;
      slave_pulses[hub_sel]++;
      mout = {mout[DW-2:0], o_hub_sin};
      if (data_idx < DW) begin
        sout = pat[hub_sel][DW-1-data_idx];
        data_idx++;
      end
    end
  end

  always @(negedge o_hub_sclk) begin
    if (o_hub_regsel) begin
      hub_sel  = hub_shift;
      data_idx = 0;
    end
  end

  // Monitor: samples 1 ns after each rising edge, scores DONE pulses.
  logic          prev_sclk = 1'b0, prev_sin = 1'b0, prev_regsel = 1'b0;
  logic [DW-1:0] last_rx = '0;
  exp_t          e;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!i_rst_n) begin
        check("reset_outputs", {19'd0, o_busy, o_done, o_rx_data, o_hub_regsel, o_hub_sclk, o_hub_sin}, 32'd0);
        last_rx = '0;
      end else begin
        if ((o_hub_sin !== prev_sin) || (o_hub_regsel !== prev_regsel))
          check("glitch_sclk_at_sin_regsel_change", {30'd0, prev_sclk, o_hub_sclk}, 32'd0);
        if (o_done) begin
          done_count++;
          check("done_has_expectation", (q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            $display("txn addr=%0d tx=%02h rx=%02h exp_rx=%02h latency=%0d", e.addr, e.tx, o_rx_data, e.rx, cyc - e.acc);
            check("rx_data", o_rx_data, e.rx);
            check("done_latency", cyc - e.acc, LAT);
            check("busy_in_done", o_busy, 1);
            check("addr_pulses", addr_pulses, AW);
            check("data_pulses", data_pulses, DW);
            check("slave_pulses_selected", slave_pulses[e.addr], DW);
            check("mout_bits", mout, e.tx);
            check("hub_select", hub_sel, e.addr);
            last_rx = e.rx;
          end
          clear_hub();
        end else begin
          check("rx_hold", o_rx_data, last_rx);
        end
      end
      prev_sclk   = o_hub_sclk;
      prev_sin    = o_hub_sin;
      prev_regsel = o_hub_regsel;
    end
  end

  task automatic start_txn(input logic [AW-1:0] a, input logic [DW-1:0] t);
    @(negedge clk);
    i_addr    = a;
    i_tx_data = t;
    i_start   = 1'b1;
    q.push_back('{a, t, pat[a], cyc + 1});
    @(negedge clk);
    i_start   = 1'b0;
    i_addr    = AW'($urandom);
    i_tx_data = DW'($urandom);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic pulse_start_busy();
    @(negedge clk);
    i_start = 1'b1;
    i_addr  = AW'($urandom);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Stimulus
  int            acc1, d0;
  logic [DW-1:0] tx2;

  initial begin
    foreach (pat[i]) pat[i] = DW'($urandom);
    pat[19] = 8'h3C;
    clear_hub();

    // Reset with START asserted: must be ignored.
    i_rst_n   = 1'b0;
    i_start   = 1'b1;
    i_addr    = 5'd3;
    i_tx_data = 8'hFF;
    repeat (3) @(negedge clk);
    i_start = 1'b0;
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy_after_reset", o_busy, 0);
    check("idle_sclk_after_reset", o_hub_sclk, 0);

    // Directed transfer to slave 19.
    start_txn(5'd19, 8'hA5);
    wait_empty();

    // Back-to-back with START held high: ADDR=0 then ADDR=31.
    tx2 = DW'($urandom);
    @(negedge clk);
    i_addr    = 5'd0;
    i_tx_data = DW'($urandom);
    i_start   = 1'b1;
    acc1      = cyc + 1;
    q.push_back('{5'd0, i_tx_data, pat[0], acc1});
    @(negedge clk);
    i_addr    = 5'd31;
    i_tx_data = tx2;
    q.push_back('{5'd31, tx2, pat[31], acc1 + LAT + 1});
    while (cyc < acc1 + LAT + 1) @(negedge clk);
    i_start = 1'b0;
    wait_empty();

    // START while busy is ignored: exactly one DONE.
    d0 = done_count;
    start_txn(5'd9, DW'($urandom));
    repeat (9) @(negedge clk);
    pulse_start_busy();
    wait_empty();
    repeat (70) @(negedge clk);
    check("single_done_with_busy_start", done_count - d0, 1);

    // Reset during data bit 3: abort, no DONE, then a clean transfer.
    d0 = done_count;
    @(negedge clk);
    i_addr    = 5'd12;
    i_tx_data = DW'($urandom);
    i_start   = 1'b1;
    acc1      = cyc + 1;
    @(negedge clk);
    i_start = 1'b0;
    while (cyc < acc1 + 36) @(negedge clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("no_done_after_abort", done_count - d0, 0);
    clear_hub();
    start_txn(5'd7, DW'($urandom));
    wait_empty();

    // Randomized transfers with random idle gaps and ignored START pulses.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_txn(AW'($urandom), DW'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        pulse_start_busy();
      end
      wait_empty();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
